sync_fifo_gen: RTL and testbench

SYNC_FIFO_GEN -- requirements
Module: sync_fifo_gen

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_dpram.sv | 21 ++
 rtl/sync_fifo_gen.sv | 118 +++++++++++
 tb/tb_sync_fifo_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO.
package fifo_pkg;
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Pointer width for a given depth; occupancy needs one extra bit to represent DEPTH itself.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_gen.sv
// Parameterised single-clock FIFO with status flags, sticky error flags and
// selectable standard / first-word-fall-through read behaviour.
module sync_fifo_gen
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int FWFT   = FIFO_STD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      rd,
  output logic [DATA_W-1:0]         data_out,
  output logic                      data_valid,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [fifo_ptr_w(DEPTH):0] fifo_cnt,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);
  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LVL);

  if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_gen: DEPTH must be a power of two in 2..1024");
  end
  if ((AF_LVL < 1) || (AF_LVL > DEPTH) || (AE_LVL < 0) || (AE_LVL > DEPTH - 1)) begin : g_bad_lvl
    $error("sync_fifo_gen: AF_LVL/AE_LVL out of range");
  end
  if ((DATA_W < 1) || (DATA_W > 64)) begin : g_bad_width
    $error("sync_fifo_gen: DATA_W must be in 1..64");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic              rd_acc, wr_acc, ovf_evt, udf_evt;

  assign empty        = (fifo_cnt == '0);
  assign full         = (fifo_cnt == DEPTH_C);
  assign almost_full  = (fifo_cnt >= AF_C);
  assign almost_empty = (fifo_cnt <= AE_C);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  assign rd_acc  = rd && !empty;
  assign wr_acc  = wr && (!full || rd_acc);
  assign ovf_evt = wr && !wr_acc;
  assign udf_evt = rd && empty;

  fifo_dpram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_acc && !rd_acc)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (rd_acc && !wr_acc) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // A fresh error wins over clr_err in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out   = empty ? '0 : head;
    assign data_valid = !empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              dv_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_acc;
        if (rd_acc) dout_q <= head;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end
endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench: three FIFO variants share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_gen;
  logic       clk = 1'b0;
  logic       rst, wr, rd, clr_err;
  logic [7:0] data_in;

  logic [7:0] s_dout, f_dout, t_dout;
  logic       s_dv, f_dv, t_dv;
  logic       s_empty, f_empty, t_empty;
  logic       s_full, f_full, t_full;
  logic       s_ae, f_ae, t_ae;
  logic       s_af, f_af, t_af;
  logic [3:0] s_cnt, f_cnt, t_cnt;
  logic       s_ovf, f_ovf, t_ovf;
  logic       s_udf, f_udf, t_udf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_dv = 1'b0;
  logic [7:0] m_dout = 8'h00;

  always #5 clk = ~clk;

  sync_fifo_gen #(.DATA_W(8), .DEPTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(s_dout), .data_valid(s_dv), .empty(s_empty), .full(s_full),
    .almost_empty(s_ae), .almost_full(s_af), .fifo_cnt(s_cnt),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err));

  sync_fifo_gen #(.DATA_W(8), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(f_dout), .data_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .fifo_cnt(f_cnt),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err));

  sync_fifo_gen #(.DATA_W(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) u_thr (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(t_dout), .data_valid(t_dv), .empty(t_empty), .full(t_full),
    .almost_empty(t_ae), .almost_full(t_af), .fifo_cnt(t_cnt),
    .overflow(t_ovf), .underflow(t_udf), .clr_err(clr_err));

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int         n;
    logic [7:0] hd;
    n  = q.size();
    hd = (n > 0) ? q[0] : 8'h00;
    chk_eq("s_cnt", s_cnt, n);
    chk_eq("s_empty", s_empty, n == 0);
    chk_eq("s_full", s_full, n == 8);
    chk_eq("s_af", s_af, n >= 7);
    chk_eq("s_ae", s_ae, n <= 1);
    chk_eq("s_ovf", s_ovf, m_ovf);
    chk_eq("s_udf", s_udf, m_udf);
    chk_eq("s_dv", s_dv, m_dv);
    chk_eq("s_dout", s_dout, m_dout);
    chk_eq("f_cnt", f_cnt, n);
    chk_eq("f_dv", f_dv, n > 0);
    chk_eq("f_dout", f_dout, hd);
    chk_eq("f_ovf", f_ovf, m_ovf);
    chk_eq("f_udf", f_udf, m_udf);
    chk_eq("t_cnt", t_cnt, n);
    chk_eq("t_af", t_af, n >= 6);
    chk_eq("t_ae", t_ae, n <= 2);
    chk_eq("t_dout", t_dout, m_dout);
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
    bit rd_ok, wr_ok;
    wr = w; data_in = d; rd = r; clr_err = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && ((q.size() < 8) || rd_ok);
      if (rd_ok) begin
        m_dout = q.pop_front();
        m_dv   = 1'b1;
      end else begin
        m_dv = 1'b0;
      end
      if (wr_ok) q.push_back(d);
      if (w && !wr_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && !rd_ok) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = 8'h00;

    // reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_eq("rst_empty", s_empty, 1);
    chk_eq("rst_ae", s_ae, 1);
    chk_eq("rst_full", s_full, 0);

    // fill / drain with overflow
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0, 0);
    chk_eq("fill_full", s_full, 1);
    chk_eq("fill_cnt", s_cnt, 8);
    step(1, 8'h09, 0, 0, 0);
    chk_eq("ovf_set", s_ovf, 1);
    chk_eq("ovf_cnt", s_cnt, 8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0, 0);
      chk_eq("drain_data", s_dout, i);
      chk_eq("drain_dv", s_dv, 1);
    end
    chk_eq("drain_empty", s_empty, 1);
    step(0, 0, 0, 0, 0);
    chk_eq("dv_one_cycle", s_dv, 0);

    // pointer wrap
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'hA0 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0);
      chk_eq("wrap_data", s_dout, 8'hA0 + 8'(i));
    end
    chk_eq("wrap_cnt", s_cnt, 0);

    // simultaneous read/write at full and empty
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    chk_eq("fullrw_cnt", s_cnt, 8);
    chk_eq("fullrw_data", s_dout, 8'h40);
    chk_eq("fullrw_ovf", s_ovf, 0);
    step(0, 0, 1, 0, 0);
    chk_eq("fullrw_next", s_dout, 8'h41);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    chk_eq("fullrw_last", s_dout, 8'h55);
    step(1, 8'h66, 1, 0, 0);
    chk_eq("emptyrw_cnt", s_cnt, 1);
    chk_eq("emptyrw_udf", s_udf, 1);
    step(0, 0, 1, 0, 0);
    chk_eq("emptyrw_data", s_dout, 8'h66);

    // first-word-fall-through
    step(0, 0, 0, 0, 1);
    step(1, 8'h5A, 0, 0, 0);
    chk_eq("fwft_data", f_dout, 8'h5A);
    chk_eq("fwft_dv", f_dv, 1);
    step(0, 0, 1, 0, 0);
    chk_eq("fwft_pop_dv", f_dv, 0);

    // thresholds and sticky-flag clearing
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 2) chk_eq("ae_at2", t_ae, 1);
      if (i == 3) chk_eq("ae_at3", t_ae, 0);
      if (i == 5) chk_eq("af_at5", t_af, 0);
      if (i == 6) chk_eq("af_at6", t_af, 1);
    end
    step(1, 8'h07, 0, 0, 0);
    step(1, 8'h08, 0, 0, 0);
    step(1, 8'h09, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);
    chk_eq("err_ovf", t_ovf, 1);
    chk_eq("err_udf", t_udf, 1);
    step(0, 0, 1, 1, 0);
    chk_eq("clr_prio_udf", t_udf, 1);
    chk_eq("clr_prio_ovf", t_ovf, 0);
    step(0, 0, 0, 1, 0);
    chk_eq("clr_udf", t_udf, 0);

    // reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 8'hC0 + 8'(i), 0, 0, 0);
    step(1, 8'hEE, 1, 1, 1);
    chk_eq("mid_rst_cnt", s_cnt, 0);
    chk_eq("mid_rst_dout", s_dout, 0);
    chk_eq("mid_rst_dv", s_dv, 0);
    step(1, 8'h33, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk_eq("post_rst_data", s_dout, 8'h33);

    // randomized traffic in phases of differing read/write bias
    for (int ph = 0; ph < 6; ph++) begin
      pw = 10 + 16 * ph;
      pr = 90 - 16 * ph;
      if (ph == 5) begin pw = 50; pr = 50; end
      for (int k = 0; k < 400; k++) begin
        step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
             $urandom_range(99) < 5, $urandom_range(199) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
